// File: rtl/bin2qdi_qdi2bin_1of2_if.sv
// Handshake bundle between the clocked host and the dual-rail QDI channel.
// Pure wiring: it adds no latency and no storage.
// Backpressure is carried by the Txe/Rxe enable rails and the rx_en permission.
interface bin2qdi_qdi2bin_1of2_if;
  logic       tx_data;
  logic       tx_go;
  logic [1:0] Tx;
  logic       Txe;
  logic [1:0] Rx;
  logic       Rxe;
  logic       rx_data;
  logic       rx_valid;
  logic       rx_en;

  // Bridge side: consumes host requests and QDI rails, produces tokens and enables.
  modport slave (
    input  tx_data, tx_go, Txe, Rx, rx_en,
    output Tx, Rxe, rx_data, rx_valid
  );

  // Host / environment side.
  modport master (
    output tx_data, tx_go, Txe, Rx, rx_en,
    input  Tx, Rxe, rx_data, rx_valid
  );
endinterface

// File: rtl/bin2qdi_qdi2bin_1of2.sv
// Bridge between a clocked binary bit and a 1-of-2 dual-rail four-phase QDI channel.
// Latency: SYNC_STAGES+1 edges from an async rail change, 1 edge from tx_go/rx_en.
// Backpressure: no new Tx token until Txe returns high; a held Rx token is acked only when rx_en=1.
module bin2qdi_qdi2bin_1of2 #(
  parameter int SYNC_STAGES = 2
) (
  input  logic                        CLK,
  input  logic                        RESET,
  bin2qdi_qdi2bin_1of2_if.slave       bus,
  inout  wire                         VDD,
  inout  wire                         GND
);

  typedef enum logic {TX_NEUTRAL, TX_DRIVEN} txState_t;
  typedef enum logic [1:0] {RX_IDLE, RX_FULL, RX_ACK} rxState_t;

  // Power pins carry no logic; fold them into a sink so they are not flagged as dangling.
  logic unusedPower;
  assign unusedPower = VDD ^ GND;

  logic [SYNC_STAGES-1:0] txeSync;
  logic [SYNC_STAGES-1:0] rx0Sync;
  logic [SYNC_STAGES-1:0] rx1Sync;
  logic                   txeS;
  logic [1:0]             rxS;

  txState_t txState, txStateNxt;
  logic [1:0] txReg, txRegNxt;

  rxState_t rxState, rxStateNxt;
  logic rxeReg, rxeNxt;
  logic rxValidReg, rxValidNxt;
  logic rxDataReg, rxDataNxt;

  // Synchronizer chains for the three asynchronous rails; stage 0 samples the pin.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      txeSync <= '0;
      rx0Sync <= '0;
      rx1Sync <= '0;
    end else begin
      txeSync[0] <= bus.Txe;
      rx0Sync[0] <= bus.Rx[0];
      rx1Sync[0] <= bus.Rx[1];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        txeSync[i] <= txeSync[i-1];
        rx0Sync[i] <= rx0Sync[i-1];
        rx1Sync[i] <= rx1Sync[i-1];
      end
    end
  end

  assign txeS = txeSync[SYNC_STAGES-1];
  assign rxS  = {rx1Sync[SYNC_STAGES-1], rx0Sync[SYNC_STAGES-1]};

  // Transmitter state and registered dual-rail output.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      txState <= TX_NEUTRAL;
      txReg   <= 2'b00;
    end else begin
      txState <= txStateNxt;
      txReg   <= txRegNxt;
    end
  end

  // Transmitter next state: capture tx_data once per token; hold it until acked and tx_go drops.
  always_comb begin
    txStateNxt = txState;
    txRegNxt   = txReg;
    case (txState)
      TX_NEUTRAL: begin
        if (bus.tx_go && txeS) begin
          txStateNxt = TX_DRIVEN;
          txRegNxt   = bus.tx_data ? 2'b10 : 2'b01;
        end
      end
      TX_DRIVEN: begin
        if (!txeS && !bus.tx_go) begin
          txStateNxt = TX_NEUTRAL;
          txRegNxt   = 2'b00;
        end
      end
      default: begin
        txStateNxt = TX_NEUTRAL;
        txRegNxt   = 2'b00;
      end
    endcase
  end

  // Receiver state and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rxState    <= RX_IDLE;
      rxeReg     <= 1'b1;
      rxValidReg <= 1'b0;
      rxDataReg  <= 1'b0;
    end else begin
      rxState    <= rxStateNxt;
      rxeReg     <= rxeNxt;
      rxValidReg <= rxValidNxt;
      rxDataReg  <= rxDataNxt;
    end
  end

  // Receiver next state: accept a one-hot token, ack on permission, release on neutral.
  always_comb begin
    rxStateNxt = rxState;
    rxeNxt     = rxeReg;
    rxValidNxt = rxValidReg;
    rxDataNxt  = rxDataReg;
    case (rxState)
      RX_IDLE: begin
        // 11 is illegal on a 1-of-2 channel and is deliberately not captured.
        if (rxS == 2'b01 || rxS == 2'b10) begin
          rxStateNxt = RX_FULL;
          rxValidNxt = 1'b1;
          rxDataNxt  = rxS[1];
        end
      end
      RX_FULL: begin
        if (bus.rx_en) begin
          rxStateNxt = RX_ACK;
          rxeNxt     = 1'b0;
        end
      end
      RX_ACK: begin
        if (rxS == 2'b00) begin
          rxStateNxt = RX_IDLE;
          rxeNxt     = 1'b1;
          rxValidNxt = 1'b0;
        end
      end
      default: begin
        rxStateNxt = RX_IDLE;
        rxeNxt     = 1'b1;
        rxValidNxt = 1'b0;
      end
    endcase
  end

  assign bus.Tx       = txReg;
  assign bus.Rxe      = rxeReg;
  assign bus.rx_valid = rxValidReg;
  assign bus.rx_data  = rxDataReg;

endmodule

// File: tb/tb_bin2qdi_qdi2bin_1of2.sv
// Directed bench for the binary/QDI bridge with a scoreboard on received tokens.
module tb_bin2qdi_qdi2bin_1of2;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  bin2qdi_qdi2bin_1of2_if bus ();

  wire vdd;
  wire gnd;
  assign vdd = 1'b1;
  assign gnd = 1'b0;

  logic       loopMode = 1'b0;
  logic [1:0] rxDrv    = 2'b00;
  logic       txeDrv   = 1'b1;

  // Async rails come either from the bench or from the DUT's own outputs (loopback).
  always_comb begin
    bus.Rx  = loopMode ? bus.Tx  : rxDrv;
    bus.Txe = loopMode ? bus.Rxe : txeDrv;
  end

  bin2qdi_qdi2bin_1of2 #(.SYNC_STAGES(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave),
    .VDD   (vdd),
    .GND   (gnd)
  );

  int   errors = 0;
  int   checks = 0;
  logic expQ[$];
  int   rxPulses = 0;
  int   txTokens = 0;
  logic prevValid = 1'b0;
  logic [1:0] prevTx = 2'b00;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Scoreboard: every new rx_valid pulse must carry the oldest outstanding value.
  always @(negedge CLK) begin
    if (bus.rx_valid === 1'b1 && prevValid !== 1'b1) begin
      rxPulses++;
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra_token observed=rx_data %0b expected=no token", bus.rx_data);
      end else begin
        chk("sb_rx_data", 8'(bus.rx_data), 8'(expQ.pop_front()));
      end
    end
    prevValid = bus.rx_valid;
    if (prevTx == 2'b00 && bus.Tx != 2'b00) txTokens++;
    prevTx = bus.Tx;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    int tokBase;
    int pulseBase;
    int bad;
    int timeouts;
    logic ok;

    bus.tx_data = 1'b0;
    bus.tx_go   = 1'b0;
    bus.rx_en   = 1'b0;

    // Reset state.
    step(2);
    chk("rst_tx", 8'(bus.Tx), 8'h0);
    chk("rst_rxe", 8'(bus.Rxe), 8'h1);
    chk("rst_rx_valid", 8'(bus.rx_valid), 8'h0);
    chk("rst_rx_data", 8'(bus.rx_data), 8'h0);
    RESET = 1'b0;
    step(3);

    // Send a 1: token appears one edge after tx_go, holds despite tx_data change.
    bus.tx_data = 1'b1;
    bus.tx_go   = 1'b1;
    chk("tx1_before_edge", 8'(bus.Tx), 8'h0);
    step(1);
    chk("tx1_driven", 8'(bus.Tx), 8'h2);
    bus.tx_data = 1'b0;
    txeDrv = 1'b0;
    step(4);
    chk("tx1_hold_go", 8'(bus.Tx), 8'h2);
    bus.tx_go = 1'b0;
    step(1);
    chk("tx1_neutral", 8'(bus.Tx), 8'h0);
    txeDrv = 1'b1;
    step(3);

    // Send a 0 with tx_go held across a full Txe low/high cycle: exactly one token.
    tokBase = txTokens;
    bus.tx_data = 1'b0;
    bus.tx_go   = 1'b1;
    step(1);
    chk("tx0_driven", 8'(bus.Tx), 8'h1);
    txeDrv = 1'b0;
    step(4);
    chk("tx0_acked_go_high", 8'(bus.Tx), 8'h1);
    txeDrv = 1'b1;
    step(4);
    chk("tx0_txe_back_go_high", 8'(bus.Tx), 8'h1);
    txeDrv = 1'b0;
    step(3);
    chk("tx0_still_driven", 8'(bus.Tx), 8'h1);
    bus.tx_go = 1'b0;
    step(1);
    chk("tx0_neutral", 8'(bus.Tx), 8'h0);
    step(1);
    chk("tx0_single_token", 8'(txTokens - tokBase), 8'h1);

    // tx_go while Txe low must wait; release of Txe takes SYNC_STAGES+1 edges.
    bus.tx_data = 1'b1;
    bus.tx_go   = 1'b1;
    step(3);
    chk("tx_wait_txe", 8'(bus.Tx), 8'h0);
    txeDrv = 1'b1;
    step(2);
    chk("tx_txe_sync_latency", 8'(bus.Tx), 8'h0);
    step(1);
    chk("tx_txe_released", 8'(bus.Tx), 8'h2);
    bus.tx_go = 1'b0;
    txeDrv = 1'b0;
    step(3);
    chk("tx_return_neutral", 8'(bus.Tx), 8'h0);
    txeDrv = 1'b1;
    step(3);

    // Receive a 1 and hold it while rx_en is low.
    rxDrv = 2'b10;
    expQ.push_back(1'b1);
    step(2);
    chk("rx1_sync_latency", 8'(bus.rx_valid), 8'h0);
    step(1);
    chk("rx1_valid", 8'(bus.rx_valid), 8'h1);
    chk("rx1_data", 8'(bus.rx_data), 8'h1);
    bad = 0;
    repeat (20) begin
      step(1);
      if (bus.Rxe !== 1'b1 || bus.rx_valid !== 1'b1) bad++;
    end
    chk("rx1_hold_full", 8'(bad), 8'h0);
    bus.rx_en = 1'b1;
    step(1);
    chk("rx1_ack", 8'(bus.Rxe), 8'h0);
    bus.rx_en = 1'b0;
    rxDrv = 2'b00;
    step(2);
    chk("rx1_ack_hold", 8'(bus.rx_valid), 8'h1);
    step(1);
    chk("rx1_idle_valid", 8'(bus.rx_valid), 8'h0);
    chk("rx1_idle_rxe", 8'(bus.Rxe), 8'h1);
    chk("rx1_data_kept", 8'(bus.rx_data), 8'h1);

    // Receive a 0 with rx_en already high.
    rxDrv = 2'b01;
    bus.rx_en = 1'b1;
    expQ.push_back(1'b0);
    step(3);
    chk("rx0_data", 8'(bus.rx_data), 8'h0);
    step(1);
    chk("rx0_ack", 8'(bus.Rxe), 8'h0);
    rxDrv = 2'b00;
    bus.rx_en = 1'b0;
    step(3);
    chk("rx0_idle", 8'(bus.rx_valid), 8'h0);

    // Illegal 11 in IDLE is ignored.
    rxDrv = 2'b11;
    step(6);
    chk("rx11_valid", 8'(bus.rx_valid), 8'h0);
    chk("rx11_rxe", 8'(bus.Rxe), 8'h1);
    rxDrv = 2'b00;
    step(3);

    // Both sides mid-handshake, then asynchronous reset.
    bus.tx_data = 1'b1;
    bus.tx_go   = 1'b1;
    rxDrv = 2'b10;
    bus.rx_en = 1'b1;
    expQ.push_back(1'b1);
    step(5);
    chk("pre_rst_tx", 8'(bus.Tx), 8'h2);
    chk("pre_rst_rxe", 8'(bus.Rxe), 8'h0);
    #1 RESET = 1'b1;
    #1;
    chk("async_rst_tx", 8'(bus.Tx), 8'h0);
    chk("async_rst_rxe", 8'(bus.Rxe), 8'h1);
    chk("async_rst_valid", 8'(bus.rx_valid), 8'h0);
    chk("async_rst_data", 8'(bus.rx_data), 8'h0);
    rxDrv = 2'b00;
    bus.rx_en = 1'b0;
    step(2);
    RESET = 1'b0;
    // Sync flops were cleared, so Txe must be re-synchronized before a new token.
    step(2);
    chk("post_rst_resync", 8'(bus.Tx), 8'h0);
    step(1);
    chk("post_rst_token", 8'(bus.Tx), 8'h2);
    bus.tx_go = 1'b0;
    txeDrv = 1'b0;
    step(3);
    txeDrv = 1'b1;
    step(3);

    // Loopback: 30 alternating tokens through the bridge into itself.
    loopMode  = 1'b1;
    bus.rx_en = 1'b1;
    pulseBase = rxPulses;
    timeouts  = 0;
    for (int i = 0; i < 30; i++) begin
      bus.tx_data = i[0];
      bus.tx_go   = 1'b1;
      expQ.push_back(i[0]);
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
        step(1);
        if (bus.Tx != 2'b00) ok = 1'b1;
      end
      if (!ok) timeouts++;
      bus.tx_go = 1'b0;
      ok = 1'b0;
      for (int k = 0; k < 40 && !ok; k++) begin
        step(1);
        if (bus.Tx == 2'b00) ok = 1'b1;
      end
      if (!ok) timeouts++;
    end
    step(10);
    chk("loop_timeouts", 8'(timeouts), 8'h0);
    chk("loop_pulses", 8'(rxPulses - pulseBase), 8'd30);
    chk("loop_queue_drained", 8'(expQ.size()), 8'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin2qdi_qdi2bin_1of2.md
BIN2QDI_QDI2BIN_1OF2 -- requirements
Module: bin2qdi_qdi2bin_1of2

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, legal 1..4: number of flops synchronizing each asynchronous QDI input (Txe, Rx[0], Rx[1]).
REQ-002 SHALL have one clock and one reset. Reset is asynchronous and active-high.
REQ-003 SHALL have port CLK, input, 1 bit: sole clock, all state updates on its rising edge.
REQ-004 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port tx_data, input, 1 bit: binary value to transmit; synchronous to CLK.
REQ-006 SHALL have port tx_go, input, 1 bit: transmit request; synchronous to CLK.
REQ-007 SHALL have port Tx, output, 2 bits: dual-rail 1-of-2 token out; Tx[1]=value 1, Tx[0]=value 0, 00=neutral.
REQ-008 SHALL have port Txe, input, 1 bit: downstream enable (1=ready/neutral, 0=token acknowledged); asynchronous.
REQ-009 SHALL have port Rx, input, 2 bits: dual-rail 1-of-2 token in; asynchronous.
REQ-010 SHALL have port Rxe, output, 1 bit: upstream enable (1=ready, 0=acknowledge).
REQ-011 SHALL have port rx_data, output, 1 bit: captured received value.
REQ-012 SHALL have port rx_valid, output, 1 bit: a received token is held.
REQ-013 SHALL have port rx_en, input, 1 bit: permission to acknowledge the held token; synchronous.
REQ-014 SHALL have ports VDD and GND, inout, 1 bit each: power pins with no logical function.

Function
REQ-015 SHALL derive txe_s and rx_s[1:0] as Txe/Rx passed through SYNC_STAGES flops; all outputs SHALL be registered.
REQ-016 Transmitter state SHALL be NEUTRAL (Tx=00) or DRIVEN (Tx one-hot).
REQ-017 NEUTRAL->DRIVEN when tx_go=1 and txe_s=1 at an edge; Tx[tx_data]=1 from that edge, tx_data captured there.
REQ-018 DRIVEN->NEUTRAL when txe_s=0 and tx_go=0 at an edge; Tx=00 from that edge.
REQ-019 In DRIVEN, Tx SHALL hold the captured value regardless of tx_data changes; Tx SHALL never be 11.
REQ-020 With tx_go still 1 after acknowledge, Tx SHALL stay DRIVEN (no duplicate token); next token needs return to NEUTRAL, then txe_s=1 and tx_go=1.
REQ-021 Receiver states IDLE (Rxe=1, rx_valid=0), FULL (Rxe=1, rx_valid=1), ACK (Rxe=0, rx_valid=1).
REQ-022 IDLE->FULL when rx_s is 01 or 10; rx_data<=rx_s[1] at that edge.
REQ-023 FULL->ACK at an edge with rx_en=1; rx_en=0 holds FULL indefinitely.
REQ-024 ACK->IDLE when rx_s=00; rx_valid<=0, Rxe<=1 same edge; rx_data holds last value.
REQ-025 rx_s=11 SHALL be ignored in IDLE (stay IDLE, no capture); in FULL/ACK any non-00 rx_s SHALL keep state.
REQ-026 Transmitter and receiver SHALL operate fully independently, simultaneous events on both sides allowed.
REQ-027 Latency: asynchronous-input change to output response = SYNC_STAGES+1 rising edges; tx_go/rx_en to response = 1 edge.

Reset
REQ-028 While RESET=1: Tx=00, Rxe=1, rx_valid=0, rx_data=0, all sync flops 0, transmitter NEUTRAL, receiver IDLE.
REQ-029 RESET asserted mid-handshake SHALL abort immediately; in-flight tokens are discarded.
REQ-030 After RESET falls, first transition SHALL need freshly synchronized inputs (≥SYNC_STAGES edges).

Verification
REQ-031 SYNC_STAGES=2, Txe=1, tx_data=1, tx_go=1 -> Tx=10 at next edge; Txe=0, then tx_go=0 -> Tx=00 within 3 edges.
REQ-032 tx_data=0 send, tx_go held 1 through Txe=0 then Txe=1 -> Tx stays 01 until tx_go=0 with Txe=0; exactly one token.
REQ-033 Rx=10, rx_en=0 -> rx_valid=1, rx_data=1 after 3 edges, Rxe stays 1 for 20 cycles; rx_en=1 -> Rxe=0 next edge; Rx=00 -> rx_valid=0, Rxe=1 after 3 edges.
REQ-034 Rx=11 in IDLE -> rx_valid stays 0, Rxe stays 1.
REQ-035 Loopback Tx->Rx, Rxe->Txe, rx_en=1, 30 tokens of alternating data -> 30 rx_valid pulses, data in order, no loss/duplication.
REQ-036 RESET=1 while Tx DRIVEN and receiver ACK -> Tx=00, Rxe=1, rx_valid=0 without a clock edge.
